// File: rtl/bus_char_framebuffer_responder.sv
// Processor-bus responder owning the GPU character framebuffer: 64-bit accesses are
// serialised into 8 byte-wide RAM cycles, while the GPU gets an independent fetch port.
module bus_char_framebuffer_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0001_0000,
  parameter int          FB_DEPTH  = 2048
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [63:0]                 address,
  input  logic [63:0]                 dataIn,
  input  logic                        read,
  input  logic                        write,
  output logic [63:0]                 dataOut,
  output logic                        dataOutEnable,
  output logic                        ready,
  output logic                        busy,
  input  logic [$clog2(FB_DEPTH)-1:0] gpuAddress,
  output logic [7:0]                  gpuData
);
  localparam int          AW        = $clog2(FB_DEPTH);
  localparam logic [63:0] LAST_ADDR = BASE_ADDR + 64'(FB_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] base_off;
  logic [63:0]   wdata;
  logic [63:0]   rbuf;
  logic          was_read;
  logic [7:0]    mem [FB_DEPTH];
  logic [7:0]    rdata;

  logic          hit;
  logic [AW-1:0] off;
  logic [AW-1:0] idx;
  logic [2:0]    lane;
  logic          mem_we;

  assign hit    = (address >= BASE_ADDR) && (address <= LAST_ADDR);
  // Low bits of the difference depend only on low bits of the operands.
  assign off    = address[AW-1:0] - BASE_ADDR[AW-1:0];
  assign idx    = base_off + AW'(cnt[2:0]);
  assign lane   = cnt[2:0] - 3'd1;
  assign mem_we = (state == S_WRITE) && !cnt[3] && !reset;

  assign busy          = (state == S_WRITE) || (state == S_READ);
  assign ready         = (state == S_DONE);
  assign dataOutEnable = (state == S_DONE) && was_read;

  // Contents survive reset; both read ports return the pre-write value.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= wdata[{cnt[2:0], 3'b000} +: 8];
    rdata <= mem[idx];
  end

  always_ff @(posedge clock) begin
    if (reset) gpuData <= 8'h00;
    else       gpuData <= mem[gpuAddress];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      base_off <= '0;
      wdata    <= 64'd0;
      rbuf     <= 64'd0;
      was_read <= 1'b0;
      dataOut  <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit && (write || read)) begin
            base_off <= off;
            wdata    <= dataIn;
            cnt      <= 4'd0;
            was_read <= !write;
            state    <= write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) state <= S_DONE;
        end
        S_READ: begin
          // Issue at cnt 0..7, capture one edge later at cnt 1..8, commit at 9.
          cnt <= cnt + 4'd1;
          if (cnt != 4'd0 && cnt <= 4'd8) rbuf[{lane, 3'b000} +: 8] <= rdata;
          if (cnt == 4'd9) begin
            dataOut <= rbuf;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_char_framebuffer_responder.sv
// Directed, table-driven bench for the framebuffer responder.
module tb_bus_char_framebuffer_responder;
  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] address, dataIn, dataOut;
  logic        read, write, dataOutEnable, ready, busy;
  logic [10:0] gpuAddress;
  logic [7:0]  gpuData;

  int total = 0;
  int bad   = 0;

  bus_char_framebuffer_responder #(.BASE_ADDR(BASE), .FB_DEPTH(2048)) dut (
    .clock(clock), .reset(reset), .address(address), .dataIn(dataIn),
    .read(read), .write(write), .dataOut(dataOut), .dataOutEnable(dataOutEnable),
    .ready(ready), .busy(busy), .gpuAddress(gpuAddress), .gpuData(gpuData)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic        rd;
    logic        wr;
    int          lat;
    int          bsy;
    logic [63:0] dout;
    logic        doe;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } ent_t;

  vec_t vecs[9];
  ent_t ents[20];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic gpu_check(input int e, input logic [7:0] exp);
    gpuAddress = 11'(e);
    tick();
    check($sformatf("gpu[%0d]", e), 64'(gpuData), 64'(exp));
  endtask

  initial begin
    int lat, bn, rcount;
    logic [63:0] dout;
    logic doe;

    vecs[0] = '{BASE,        64'h4847_4645_4443_4241, 1'b0, 1'b1,  9,  9, 64'h0, 1'b0};
    vecs[1] = '{BASE,        64'h0,                   1'b1, 1'b0, 10, 10, 64'h4847_4645_4443_4241, 1'b1};
    vecs[2] = '{BASE + 2044, 64'h0807_0605_0403_0201, 1'b0, 1'b1,  9,  9, 64'h4847_4645_4443_4241, 1'b0};
    vecs[3] = '{BASE + 2044, 64'h0,                   1'b1, 1'b0, 10, 10, 64'h0807_0605_0403_0201, 1'b1};
    vecs[4] = '{BASE + 2048, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1, -1,  0, 64'h0807_0605_0403_0201, 1'b0};
    vecs[5] = '{BASE - 1,    64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1, -1,  0, 64'h0807_0605_0403_0201, 1'b0};
    vecs[6] = '{BASE + 4096, 64'h0,                   1'b1, 1'b0, -1,  0, 64'h0807_0605_0403_0201, 1'b0};
    vecs[7] = '{BASE + 8,    64'h1122_3344_5566_7788, 1'b1, 1'b1,  9,  9, 64'h0807_0605_0403_0201, 1'b0};
    vecs[8] = '{BASE + 8,    64'h0,                   1'b1, 1'b0, 10, 10, 64'h1122_3344_5566_7788, 1'b1};

    ents[0]  = '{0,    8'h05}; ents[1]  = '{1,    8'h06};
    ents[2]  = '{2,    8'h07}; ents[3]  = '{3,    8'h08};
    ents[4]  = '{4,    8'h45}; ents[5]  = '{5,    8'h46};
    ents[6]  = '{6,    8'h47}; ents[7]  = '{7,    8'h48};
    ents[8]  = '{2044, 8'h01}; ents[9]  = '{2045, 8'h02};
    ents[10] = '{2046, 8'h03}; ents[11] = '{2047, 8'h04};
    ents[12] = '{8,    8'h88}; ents[13] = '{9,    8'h77};
    ents[14] = '{10,   8'h66}; ents[15] = '{11,   8'h55};
    ents[16] = '{12,   8'h44}; ents[17] = '{13,   8'h33};
    ents[18] = '{14,   8'h22}; ents[19] = '{15,   8'h11};

    reset = 1'b1; address = 64'h0; dataIn = 64'h0; read = 1'b0; write = 1'b0;
    gpuAddress = 11'd0;
    repeat (3) tick();
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_doe",   64'(dataOutEnable), 64'd0);
    check("rst_dout",  dataOut, 64'h0);
    check("rst_gpu",   64'(gpuData), 64'h0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      address = vecs[v].addr; dataIn = vecs[v].data;
      read = vecs[v].rd; write = vecs[v].wr;
      tick();
      read = 1'b0; write = 1'b0;
      lat = -1; bn = 0;
      for (int t = 0; t <= 20; t++) begin
        if (busy) bn++;
        if (ready) begin lat = t; break; end
        tick();
      end
      dout = dataOut; doe = dataOutEnable;
      check($sformatf("v%0d_lat", v),  64'(lat), 64'(vecs[v].lat));
      check($sformatf("v%0d_busy", v), 64'(bn), 64'(vecs[v].bsy));
      check($sformatf("v%0d_dout", v), dout, vecs[v].dout);
      check($sformatf("v%0d_doe", v),  64'(doe), 64'(vecs[v].doe));
      tick();
      check($sformatf("v%0d_pulse_end", v), 64'({ready, dataOutEnable}), 64'd0);
    end

    for (int i = 0; i < 20; i++) gpu_check(ents[i].idx, ents[i].val);

    // Reset four cycles into a write of all-ones over zeroed entries 16..23.
    address = BASE + 16; dataIn = 64'h0; write = 1'b1;
    tick(); write = 1'b0;
    repeat (12) tick();
    dataIn = 64'hFFFF_FFFF_FFFF_FFFF; write = 1'b1;
    tick(); write = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_dout", dataOut, 64'h0);
    rcount = 0;
    for (int t = 0; t < 12; t++) begin
      if (ready) rcount++;
      tick();
    end
    check("rst_mid_no_ready", 64'(rcount), 64'd0);
    for (int e = 16; e < 24; e++) gpu_check(e, (e < 19) ? 8'hFF : 8'h00);

    // GPU read-before-write on entry 5, plus a stray strobe while busy.
    gpuAddress = 11'd5;
    address = BASE + 5; dataIn = 64'h0000_0000_0000_007A; write = 1'b1;
    tick(); write = 1'b0;
    check("rbw_pre", 64'(gpuData), 64'h46);
    tick();
    check("rbw_old", 64'(gpuData), 64'h46);
    address = BASE + 16; dataIn = 64'h0; write = 1'b1;
    tick(); write = 1'b0;
    check("rbw_new", 64'(gpuData), 64'h7A);
    lat = -1;
    for (int t = 2; t <= 20; t++) begin
      if (ready) begin lat = t; break; end
      tick();
    end
    check("rbw_lat", 64'(lat), 64'd9);
    tick();
    rcount = 0;
    for (int t = 0; t < 12; t++) begin
      if (ready || busy) rcount++;
      tick();
    end
    check("stray_ignored", 64'(rcount), 64'd0);
    gpu_check(16, 8'hFF);
    gpu_check(5, 8'h7A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
